filt_ppd_mac: RTL
=================

Name: filt_ppd_mac

Overview:
- Polyphase FIR decimator by gp_decimation_factor (M). It is the receive-side counterpart of the team's polyphase interpolator.
- Accepts one signed sample per enabled clock and keeps an (L-1)-deep sample delay line.
- On every M-th accepted sample it evaluates the full L-tap symmetric FIR and registers one output sample with a one-cycle valid strobe.
- Coefficients come from the shared filt_coeff.v table (half-length array c_coeff, symmetric).

Parameters:
- gp_idata_width, 8, input sample width (signed)
- gp_decimation_factor, 4, decimation ratio M (>=2)
- gp_coeff_length, 12, FIR length L (>= M)
- gp_coeff_width, 8, coefficient width (signed)
- gp_fold, 1, 1 = pre-add symmetric taps (ceil(L/2) multipliers); 0 = L multipliers. Outputs are bit-identical either way.
- gp_odata_width, gp_idata_width+gp_coeff_width+$clog2(gp_coeff_length), output width (signed)

Ports:
- i_clk  in  1  rising-edge clock
- i_rst_an  in  1  reset; asynchronous, active-low
- i_ena  in  1  sample strobe; high = i_data is valid this cycle
- i_clr  in  1  synchronous clear of phase and delay line
- i_data  in  gp_idata_width  input sample, signed
- o_data  out  gp_odata_width  decimated output, signed, held between updates
- o_valid  out  1  one-cycle pulse, high the cycle after o_data updates

Behaviour:
Coefficient mapping:
- h[k] = c_coeff[k] for k < ceil(L/2); otherwise h[k] = c_coeff[L-1-k].

Reset (i_rst_an low, asynchronous):
- Delay line x_d[0..L-2] = 0, phase counter r_phase = 0, o_data = 0, o_valid = 0.
- Reset asserted mid-frame discards any partial frame. The first output after release needs M fresh enables.

Clear (i_clr high at a clock edge):
- Same effect as reset but synchronous.
- i_clr has priority over i_ena; a sample presented in the same cycle is dropped.

Accepted sample (i_ena high, i_clr low):
- Shift the delay line: x_d[0] <= i_data, x_d[k] <= x_d[k-1].
- r_phase <= (r_phase == M-1) ? 0 : r_phase+1.

Output (i_ena high and r_phase == M-1):
- o_data <= h[0]*i_data + sum_{k=1..L-1} h[k]*x_d[k-1], evaluated with the pre-shift contents.
- o_valid <= 1 for exactly one cycle; o_valid is 0 on all other cycles.
- Latency: one clock from the M-th accepted sample to o_data / o_valid.

i_ena low:
- All state holds and o_valid = 0.
- Gaps of any length between enables do not change the output sequence.

Arithmetic:
- Products are full precision, gp_idata_width+gp_coeff_width bits.
- Accumulation is sign-extended to gp_odata_width; no saturation, no rounding.
- Fold path: the pre-add x[k]+x[L-1-k] is one bit wider. For odd L the centre tap is not folded.

Frame alignment:
- The first output after reset covers input samples 0..M-1, with sample M-1 aligned to h[0].

Decomposition:
- Shared package/include holds:
  - `DIV ceiling-divide macro
  - width localparams (c_coeff_2, c_mul_out_width, c_sum_out_width)
  - the filt_coeff.v coefficient table
- Sub-module: reuse the existing dff for each delay-line tap and for the o_data/o_valid registers.
- Phase counter and the MAC tree stay in the top module.

Test Plan:
- Impulse: reset, then i_ena every cycle with data 1,0,0,... (zeros for 16 samples) -> o_valid on enables 4,8,12; o_data = h[3], h[7], h[11] (c_coeff[3], c_coeff[4], c_coeff[0]); then 0.
- Shifted impulse: the value 1 is the 4th sample (index 3) -> outputs h[0], h[4], h[8], then 0.
- DC and extremes: constant i_data = -128 for 16 samples -> from the 3rd output on, o_data = -128 * sum(h); matches the golden model bit-exactly with no wrap.
- Gapped enable: the impulse test with i_ena high one cycle in three -> identical o_data sequence; o_valid only on every 4th enable; o_data holds between pulses.
- Mid-operation reset / clear: after 2 samples assert i_rst_an low for 1 cycle -> o_data = 0, o_valid = 0, first new o_valid after 4 more enables. Repeat using i_clr with i_ena = 1 in the same cycle -> that sample is dropped.
- Fold equivalence: random signed stimulus of 1000 samples with gp_fold = 0 and gp_fold = 1, plus L = 11, M = 3 -> o_data streams identical to each other and to the reference model.

Source files
------------

// File: rtl/filt_ppd_mac_pkg.sv
// -----------------------------------------------------------------------------
// filt_ppd_mac_pkg
// Shared definitions for the polyphase FIR decimator:
//   - `DIV ceiling-divide macro
//   - width helper functions used to derive c_coeff_2 / c_mul_out_width /
//     c_sum_out_width inside the filter
//   - the half-length symmetric coefficient table c_coeff (filt_coeff table)
// -----------------------------------------------------------------------------
`ifndef FILT_PPD_MAC_DIV
`define FILT_PPD_MAC_DIV
`define DIV(a, b) (((a) + (b) - 1) / (b))
`endif

package filt_ppd_mac_pkg;

  // Table geometry: supports filters up to 2*c_coeff_depth taps.
  localparam int c_coeff_depth     = 16;
  localparam int c_coeff_idx_width = 4;

  // Half-length table of the symmetric prototype filter; h[k] = h[L-1-k].
  localparam logic signed [7:0] c_coeff [0:c_coeff_depth-1] = '{
    -8'sd3,  8'sd5,   8'sd12,  8'sd30,  8'sd55,  8'sd70,  8'sd78,  8'sd82,
    -8'sd4,  8'sd6,  -8'sd9,   8'sd11, -8'sd13,  8'sd15, -8'sd17,  8'sd19
  };

  // Number of distinct coefficients of an L-tap symmetric filter.
  function automatic int coeff_half(input int l);
    return `DIV(l, 2);
  endfunction

  // Product width; the folded path multiplies a pre-added (one bit wider) operand.
  function automatic int mul_out_width(input int iw, input int cw, input int fold);
    return (fold != 0) ? (iw + cw + 1) : (iw + cw);
  endfunction

endpackage

// File: rtl/filt_ppd_mac_dff.sv
// -----------------------------------------------------------------------------
// filt_ppd_mac_dff
// Generic enabled register with asynchronous active-low reset and synchronous
// clear (clear has priority over enable). Used for the delay-line taps and
// the output registers of the decimator.
// Ports:
//   i_clk     rising-edge clock
//   i_rst_an  asynchronous reset, active low
//   i_ena     load enable
//   i_clr     synchronous clear to zero
//   i_data    next value
//   o_data    registered value
// -----------------------------------------------------------------------------
module filt_ppd_mac_dff #(
  parameter int gp_width = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_an,
  input  logic                i_ena,
  input  logic                i_clr,
  input  logic [gp_width-1:0] i_data,
  output logic [gp_width-1:0] o_data
);

  // Storage element: reset, then clear, then enabled load.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      o_data <= '0;
    end else if (i_clr) begin
      o_data <= '0;
    end else if (i_ena) begin
      o_data <= i_data;
    end else begin
      o_data <= o_data;
    end
  end

endmodule

// File: rtl/filt_ppd_mac.sv
// -----------------------------------------------------------------------------
// filt_ppd_mac
// Polyphase FIR decimator by M. Each enabled sample is shifted into an
// (L-1)-deep delay line; on every M-th accepted sample the full L-tap
// symmetric FIR is evaluated over {i_data, delay line} and registered,
// together with a one-cycle o_valid strobe.
// Ports:
//   i_clk     rising-edge clock
//   i_rst_an  asynchronous reset, active low
//   i_ena     sample strobe (i_data valid)
//   i_clr     synchronous clear of phase, delay line and output
//   i_data    signed input sample
//   o_data    signed decimated output, held between updates
//   o_valid   one-cycle pulse after o_data updates
// -----------------------------------------------------------------------------
module filt_ppd_mac
  import filt_ppd_mac_pkg::*;
#(
  parameter int gp_idata_width       = 8,
  parameter int gp_decimation_factor = 4,
  parameter int gp_coeff_length      = 12,
  parameter int gp_coeff_width       = 8,
  parameter int gp_fold              = 1,
  parameter int gp_odata_width       = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_an,
  input  logic                      i_ena,
  input  logic                      i_clr,
  input  logic [gp_idata_width-1:0] i_data,
  output logic [gp_odata_width-1:0] o_data,
  output logic                      o_valid
);

  localparam int c_coeff_2       = coeff_half(gp_coeff_length);
  localparam int c_mul_out_width = mul_out_width(gp_idata_width, gp_coeff_width, gp_fold);
  localparam int c_sum_out_width = gp_odata_width;
  localparam int c_phase_width   = $clog2(gp_decimation_factor);
  localparam logic [c_phase_width-1:0] c_phase_last = c_phase_width'(gp_decimation_factor - 1);

  // Expand the half-length table into tap k of the symmetric filter.
  function automatic logic signed [gp_coeff_width-1:0] tap_coeff(input int k);
    int idx;
    idx = (k < c_coeff_2) ? k : (gp_coeff_length - 1 - k);
    return gp_coeff_width'(c_coeff[idx[c_coeff_idx_width-1:0]]);
  endfunction

  logic [c_phase_width-1:0]         phase_r;
  logic                             fire_s;
  logic signed [gp_idata_width-1:0] x_d_s [0:gp_coeff_length-2];
  logic signed [gp_idata_width-1:0] win_s [0:gp_coeff_length-1];
  logic signed [c_sum_out_width-1:0] sum_s;

  // Phase counter: counts accepted samples modulo M.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      phase_r <= '0;
    end else if (i_clr) begin
      phase_r <= '0;
    end else if (i_ena) begin
      phase_r <= (phase_r == c_phase_last) ? '0 : phase_r + c_phase_width'(1);
    end else begin
      phase_r <= phase_r;
    end
  end

  // The M-th accepted sample of a frame produces an output; clear drops it.
  assign fire_s = i_ena & ~i_clr & (phase_r == c_phase_last);

  // FIR window: tap 0 is the incoming sample, tap k the pre-shift delay line.
  always_comb begin
    win_s[0] = i_data;
    for (int k = 1; k < gp_coeff_length; k++) begin
      win_s[k] = x_d_s[k-1];
    end
  end

  // Delay line: tap k loads window element k, so the line shifts by one.
  for (genvar k = 0; k < gp_coeff_length - 1; k++) begin : g_tap
    filt_ppd_mac_dff #(.gp_width(gp_idata_width)) u_tap (
      .i_clk    (i_clk),
      .i_rst_an (i_rst_an),
      .i_ena    (i_ena),
      .i_clr    (i_clr),
      .i_data   (win_s[k]),
      .o_data   (x_d_s[k])
    );
  end

  if (gp_fold != 0) begin : g_fold
    // Folded MAC: pre-add mirrored taps; for odd L the centre tap stands alone.
    always_comb begin
      logic signed [gp_idata_width:0]    pre_v;
      logic signed [c_mul_out_width-1:0] prod_v;
      pre_v  = '0;
      prod_v = '0;
      sum_s  = '0;
      for (int k = 0; k < c_coeff_2; k++) begin
        if (k == gp_coeff_length - 1 - k) begin
          pre_v = (gp_idata_width + 1)'(win_s[k]);
        end else begin
          pre_v = (gp_idata_width + 1)'(win_s[k]) +
                  (gp_idata_width + 1)'(win_s[gp_coeff_length-1-k]);
        end
        prod_v = c_mul_out_width'(pre_v) * c_mul_out_width'(tap_coeff(k));
        sum_s  = sum_s + c_sum_out_width'(prod_v);
      end
    end
  end else begin : g_direct
    // Direct MAC: one full-precision product per tap.
    always_comb begin
      logic signed [c_mul_out_width-1:0] prod_v;
      prod_v = '0;
      sum_s  = '0;
      for (int k = 0; k < gp_coeff_length; k++) begin
        prod_v = c_mul_out_width'(win_s[k]) * c_mul_out_width'(tap_coeff(k));
        sum_s  = sum_s + c_sum_out_width'(prod_v);
      end
    end
  end

  filt_ppd_mac_dff #(.gp_width(gp_odata_width)) u_odata (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_ena    (fire_s),
    .i_clr    (i_clr),
    .i_data   (sum_s),
    .o_data   (o_data)
  );

  filt_ppd_mac_dff #(.gp_width(1)) u_ovalid (
    .i_clk    (i_clk),
    .i_rst_an (i_rst_an),
    .i_ena    (1'b1),
    .i_clr    (i_clr),
    .i_data   (fire_s),
    .o_data   (o_valid)
  );

endmodule
